// File: rtl/ysyx_24110006_mem_responder.sv
// Memory-side responder: accepts one word read or byte-masked write at a time,
// waits a fixed latency, commits the access and holds the response until taken.
module ysyx_24110006_mem_responder #(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_wen,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_wmask,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err
);

  localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [32:0] BASE_EXT  = {1'b0, BASE_ADDR};
  // 33-bit window end so a window touching the top of the address space does not wrap
  localparam logic [32:0] LIMIT_EXT = BASE_EXT + (33'(DEPTH) << 2);
  localparam logic [3:0]  CNT_INIT  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wen_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wmask_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic                  accept, commit, commit_en;
  logic                  c_wen;
  logic [31:0]           c_addr, c_wdata;
  logic [3:0]            c_wmask;
  logic [32:0]           c_addr_ext;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] c_idx;
  logic [31:0]           rd_word;

  assign accept = i_req_valid && (state_q == IDLE) && !i_reset;

  // With single-cycle latency the commit edge is the accept edge, so the
  // access must use the live request rather than the latched copy.
  generate
    if (LATENCY == 1) begin : g_direct
      assign c_wen   = i_req_wen;
      assign c_addr  = i_req_addr;
      assign c_wdata = i_req_wdata;
      assign c_wmask = i_req_wmask;
    end else begin : g_latched
      assign c_wen   = wen_q;
      assign c_addr  = addr_q;
      assign c_wdata = wdata_q;
      assign c_wmask = wmask_q;
    end
  endgenerate

  assign c_addr_ext = {1'b0, c_addr[31:2], 2'b00};
  assign in_range   = (c_addr_ext >= BASE_EXT) && (c_addr_ext < LIMIT_EXT);
  assign c_idx      = DEPTH_LOG2'((c_addr - BASE_ADDR) >> 2);
  assign commit_en  = commit && !i_reset;

  // Next-state logic: accept in IDLE, count down in BUSY, wait for handshake in RESP
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP: begin
        if (i_resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and response registers; reset drops any pending transaction
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (commit_en) begin
        rdata_q <= (!c_wen && in_range) ? rd_word : 32'd0;
        err_q   <= !in_range;
      end
    end
  end

  // Request payload capture; only meaningful after an accept so no reset needed
  always_ff @(posedge i_clock) begin
    if (accept) begin
      wen_q   <= i_req_wen;
      addr_q  <= i_req_addr;
      wdata_q <= i_req_wdata;
      wmask_q <= i_req_wmask;
    end
  end

  // One byte-wide array per lane so each byte enable maps to its own write port
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      // Byte write on the commit edge for in-range, enabled lanes only
      always_ff @(posedge i_clock) begin
        if (commit_en && c_wen && in_range && c_wmask[gi])
          lane_mem[c_idx] <= c_wdata[8*gi +: 8];
      end

      assign rd_word[8*gi +: 8] = lane_mem[c_idx];
    end
  endgenerate

  assign o_req_ready  = (state_q == IDLE);
  assign o_resp_valid = (state_q == RESP);
  assign o_resp_rdata = rdata_q;
  assign o_resp_err   = err_q;

endmodule

// File: tb/tb_ysyx_24110006_mem_responder.sv
// Directed bench: LATENCY=2 instance for the main sequence, LATENCY=1 instance
// for back-to-back issue.
module tb_ysyx_24110006_mem_responder;

  logic clk = 1'b0;
  logic rst;

  logic        req_valid, req_wen, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wmask;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  logic        r1_valid, r1_wen, r1_resp_ready;
  logic [31:0] r1_addr, r1_wdata;
  logic [3:0]  r1_wmask;
  logic        r1_req_ready, r1_resp_valid, r1_resp_err;
  logic [31:0] r1_resp_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_24110006_mem_responder #(.DEPTH_LOG2(12), .BASE_ADDR(32'h8000_0000), .LATENCY(2)) u_dut (
    .i_clock(clk), .i_reset(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_wen(req_wen),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_wmask(req_wmask),
    .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
    .o_resp_rdata(resp_rdata), .o_resp_err(resp_err)
  );

  ysyx_24110006_mem_responder #(.DEPTH_LOG2(12), .BASE_ADDR(32'h8000_0000), .LATENCY(1)) u_dut1 (
    .i_clock(clk), .i_reset(rst),
    .i_req_valid(r1_valid), .o_req_ready(r1_req_ready), .i_req_wen(r1_wen),
    .i_req_addr(r1_addr), .i_req_wdata(r1_wdata), .i_req_wmask(r1_wmask),
    .o_resp_valid(r1_resp_valid), .i_resp_ready(r1_resp_ready),
    .o_resp_rdata(r1_resp_rdata), .o_resp_err(r1_resp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One LATENCY=2 transaction with resp_ready held high; starts and ends in IDLE
  task automatic txn(input string tag, input logic wen, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] mask,
                     input logic [31:0] exp_rd, input logic exp_err);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wmask = mask;
    step();
    req_valid = 1'b0;
    chk({tag, "_busy_valid"}, 32'(resp_valid), 32'd0);
    step();
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, "_rdata"}, resp_rdata, exp_rd);
    chk({tag, "_err"}, 32'(resp_err), 32'(exp_err));
    step();
    chk({tag, "_idle"}, 32'(req_ready), 32'd1);
    $display("txn %s wen=%0d addr=%h rdata=%h err=%0d", tag, wen, addr, resp_rdata, resp_err);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0; req_wmask = 0; resp_ready = 1;
    r1_valid = 0; r1_wen = 0; r1_addr = 0; r1_wdata = 0; r1_wmask = 0; r1_resp_ready = 1;
    #2;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    // 1: write then read back
    txn("t1_wr", 1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
    txn("t1_rd", 1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);

    // 2: byte mask merge
    txn("t2_wr_full", 1'b1, 32'h8000_0004, 32'h1122_3344, 4'hF, 32'h0, 1'b0);
    txn("t2_wr_mask", 1'b1, 32'h8000_0004, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0);
    txn("t2_rd", 1'b0, 32'h8000_0004, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0);

    // 3: range boundaries and empty mask
    txn("t3_rd_below", 1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 32'h0, 1'b1);
    txn("t3_wr_above", 1'b1, 32'h8000_4000, 32'h5555_5555, 4'hF, 32'h0, 1'b1);
    txn("t3_wr_top", 1'b1, 32'h8000_3FFC, 32'h0A0B_0C0D, 4'hF, 32'h0, 1'b0);
    txn("t3_rd_top", 1'b0, 32'h8000_3FFC, 32'h0, 4'h0, 32'h0A0B_0C0D, 1'b0);
    txn("t3_wr_nomask", 1'b1, 32'h8000_0000, 32'h1234_5678, 4'h0, 32'h0, 1'b0);
    txn("t3_rd_base", 1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);

    // 4: backpressure with an ignored request during RESP
    resp_ready = 1'b0;
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0004; req_wmask = 4'h0;
    step();
    req_valid = 1'b0;
    step();
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0000; req_wdata = 32'h0; req_wmask = 4'hF;
    for (int k = 0; k < 5; k++) begin
      chk("t4_valid", 32'(resp_valid), 32'd1);
      chk("t4_rdata", resp_rdata, 32'h11BB_33DD);
      chk("t4_err", 32'(resp_err), 32'd0);
      chk("t4_req_ready", 32'(req_ready), 32'd0);
      $display("t4 hold cycle %0d rdata=%h", k, resp_rdata);
      step();
    end
    resp_ready = 1'b1; req_valid = 1'b0;
    step();
    chk("t4_idle_ready", 32'(req_ready), 32'd1);
    chk("t4_idle_valid", 32'(resp_valid), 32'd0);
    txn("t4_rd_base", 1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);

    // 5: asynchronous reset while BUSY discards the write
    txn("t5_wr_prior", 1'b1, 32'h8000_0008, 32'h1234_5678, 4'hF, 32'h0, 1'b0);
    txn("t5_rd_prior", 1'b0, 32'h8000_0008, 32'h0, 4'h0, 32'h1234_5678, 1'b0);
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0008; req_wdata = 32'hCAFE_F00D; req_wmask = 4'hF;
    step();
    req_valid = 1'b0;
    chk("t5_busy_ready", 32'(req_ready), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_valid", 32'(resp_valid), 32'd0);
    chk("t5_async_rdata", resp_rdata, 32'd0);
    chk("t5_async_ready", 32'(req_ready), 32'd1);
    $display("t5 async reset rdata=%h ready=%0d", resp_rdata, req_ready);
    @(negedge clk);
    rst = 1'b0;
    step();
    txn("t5_rd_after", 1'b0, 32'h8000_0008, 32'h0, 4'h0, 32'h1234_5678, 1'b0);

    // 6: LATENCY=1 with continuous request valid
    for (int i = 0; i < 4; i++) begin
      r1_valid = 1'b1;
      r1_wen   = (i < 2);
      r1_addr  = 32'h8000_0000 + 32'(4 * (i % 2));
      r1_wdata = 32'((i % 2) + 1) * 32'h1111_1111;
      r1_wmask = 4'hF;
      step();
      chk("t6_resp_valid", 32'(r1_resp_valid), 32'd1);
      chk("t6_req_ready_busy", 32'(r1_req_ready), 32'd0);
      chk("t6_rdata", r1_resp_rdata, (i < 2) ? 32'h0 : 32'((i % 2) + 1) * 32'h1111_1111);
      chk("t6_err", 32'(r1_resp_err), 32'd0);
      $display("t6 txn %0d wen=%0d rdata=%h", i, r1_wen, r1_resp_rdata);
      step();
      chk("t6_idle_valid", 32'(r1_resp_valid), 32'd0);
      chk("t6_idle_ready", 32'(r1_req_ready), 32'd1);
    end
    r1_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_24110006_mem_responder.md
Name: ysyx_24110006_mem_responder

Overview:
Memory-side responder for the core's request/response data-memory interface, sitting at the far end of the LSU/IFU request channel. It accepts one word-granular read or byte-masked write at a time, models a fixed access latency, and returns a response with data and an error flag. It holds a word-addressed storage array mapped at a base address. The team uses it as the simulation and FPGA data store behind the load/store unit.

Parameters:
DEPTH_LOG2, 12, log2 of the number of 32-bit words in the array.
BASE_ADDR, 32'h80000000, byte address of word 0.
LATENCY, 2, cycles from request acceptance to first response-valid cycle; legal values are 1 to 15.

Ports:
i_clock  input  1  clock; all state updates on the rising edge.
i_reset  input  1  asynchronous, active-high reset.
i_req_valid  input  1  request present.
o_req_ready  output  1  responder can accept a request.
i_req_wen  input  1  1 = write, 0 = read.
i_req_addr  input  32  byte address; bits [1:0] ignored.
i_req_wdata  input  32  write data, lane-aligned.
i_req_wmask  input  4  byte enables; bit n enables wdata[8n+7:8n].
o_resp_valid  output  1  response present.
i_resp_ready  input  1  requester takes the response.
o_resp_rdata  output  32  read data; 0 for writes and errors.
o_resp_err  output  1  address out of range.

Behaviour:
- The block has one clock domain. Reset is asynchronous and active-high on i_reset.
- FSM states are IDLE, BUSY and RESP. A down-counter cnt is 4 bits wide.
- o_req_ready = (state == IDLE). o_resp_valid = (state == RESP). Both are decoded from registered state only; no input reaches an output combinationally.
- Request acceptance:
  - A request is accepted when i_req_valid and o_req_ready are both high at a rising edge.
  - On that edge the block latches wen, addr, wdata and wmask.
  - If LATENCY == 1 the FSM goes to RESP. Otherwise it goes to BUSY with cnt = LATENCY-1.
- BUSY: cnt decrements on each edge. On the edge where cnt == 1, the FSM goes to RESP.
- Timing: a request accepted in cycle c has o_resp_valid first high in cycle c+LATENCY.
- Access commit happens on the edge that enters RESP:
  - The word index is (addr - BASE_ADDR) >> 2.
  - The address is in range iff BASE_ADDR <= addr < BASE_ADDR + 4*2^DEPTH_LOG2, compared unsigned with 33-bit arithmetic so there is no wrap.
  - In-range write: only the enabled bytes are updated; o_resp_rdata = 0; o_resp_err = 0.
  - wmask == 0 write: the array is unchanged and the response is normal.
  - In-range read: o_resp_rdata = the word at the commit edge; o_resp_err = 0.
  - Out of range, read or write: no array change; o_resp_rdata = 0; o_resp_err = 1.
- RESP:
  - o_resp_rdata and o_resp_err stay stable until a handshake.
  - On i_resp_ready high at an edge, the FSM returns to IDLE.
  - The response-handshake cycle accepts no new request, so at most one transaction is outstanding.
  - Minimum issue spacing is LATENCY+1 cycles.
- In IDLE and BUSY, o_resp_rdata and o_resp_err hold their last values but are meaningless while o_resp_valid = 0.
- i_req_* changes while o_req_ready = 0 are ignored.
- Reset:
  - Values: state = IDLE, cnt = 0, o_resp_valid = 0, o_req_ready = 1 (after reset deasserts), o_resp_rdata = 0, o_resp_err = 0.
  - The array is not cleared.
  - Reset asserted mid-transaction, in BUSY, discards the pending write; the array is untouched.
  - Reset asserted in RESP drops the response.
- Read-after-write: a read accepted after a write's response handshake returns the written data.

Test Plan:
1. LATENCY=2: write addr 80000000, wdata DEADBEEF, wmask F, resp_ready=1 -> resp_valid in cycle c+2, err=0, rdata=0. Then read 80000000 -> rdata DEADBEEF, err=0.
2. Byte mask: write 80000004 = 11223344 with mask F, then write 80000004 = AABBCCDD with mask 0101 -> read returns 11BB33DD.
3. Out of range: read 7FFFFFFC, and write 80004000 with DEPTH_LOG2=12 -> err=1, rdata=0; the word at 80000000 is unchanged.
4. Backpressure: read with resp_ready held 0 for 5 cycles -> resp_valid, rdata and err stable for all 5 cycles; req_ready=0 throughout; a new req_valid is not accepted; IDLE is reached the cycle after resp_ready=1.
5. Reset mid-operation: write 80000008 = CAFEF00D, assert reset while in BUSY -> outputs reset immediately (asynchronous); a subsequent read of 80000008 returns the prior contents.
6. LATENCY=1 back-to-back: continuous req_valid with resp_ready=1 -> one transaction every 2 cycles; resp_valid high in the cycle after each accept.
